clock_ui_controller: RTL and testbench
======================================

Name: clock_ui_controller

Overview:
- Front-panel sequencer for the time-adjust datapath.
- Converts three raw push-buttons (mode, sel, inc) into the registered control strobes that datapath consumes: adjust_mode, timezone_mode, one-cycle sel and inc pulses.
- Also provides debouncing, inc auto-repeat, an inactivity timeout back to run mode, and a field index/blink indication for the display.
- Sits between the board buttons and the adjust datapath; the display driver uses field_idx and blink.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a button level change (1..2^24-1).
- REPEAT_DELAY, 500000: cycles inc must be held after its press pulse before auto-repeat starts.
- REPEAT_RATE, 100000: cycles between auto-repeat inc pulses.
- IDLE_TIMEOUT, 10000000: cycles with no accepted press before leaving ADJUST/TZ.
- BLINK_HALF, 250000: half-period of blink, in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- btn_mode  in  1  raw mode button, active-high, asynchronous.
- btn_sel  in  1  raw select button, active-high, asynchronous.
- btn_inc  in  1  raw increment button, active-high, asynchronous.
- adjust_mode  out  1  high while FSM is in ADJUST.
- timezone_mode  out  1  high while FSM is in TZ.
- sel  out  1  one-cycle select strobe.
- inc  out  1  one-cycle increment strobe.
- field_idx  out  3  mirror of the datapath field selector (0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year).
- blink  out  1  display blink enable for the selected field.

Behaviour:
- Reset (rst low, asynchronous): all synchronizer, debounce and counter registers clear to 0; FSM enters RUN. Outputs: adjust_mode=0, timezone_mode=0, sel=0, inc=0, field_idx=0, blink=0.
- Synchronizer: each button passes through its own 2-FF synchronizer.
- Debounce, per button:
  - A 24-bit counter increments while the synchronized level differs from the stable level, and clears to 0 when it matches.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synchronized level and the counter clears.
  - Press event = stable level 0->1; it is a single-cycle internal pulse.
  - Latency: a clean raw rising edge produces the corresponding output strobe exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples raw high.
  - Releases and glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: RUN, ADJUST, TZ.
  - A mode press advances RUN->ADJUST->TZ->RUN.
  - adjust_mode and timezone_mode are registered decodes of the state and change on the same edge as the state.
- sel output:
  - Pulses for exactly one cycle on a sel press, only in ADJUST or TZ.
  - On the same edge, field_idx advances and wraps 5->0.
  - field_idx is not cleared on a mode change; only rst clears it, keeping it consistent with the datapath selector.
- inc output:
  - Allowed only in ADJUST or TZ.
  - On an inc press, inc pulses one cycle.
  - While stable inc stays high, the next pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_RATE cycles.
  - Stable release, or leaving ADJUST/TZ, clears the repeat counter immediately.
  - In RUN, inc presses and holds are ignored and no pulses are produced.
- Priority within one cycle: mode > sel > inc.
  - A mode press suppresses any sel/inc pulse that cycle.
  - A sel press suppresses an inc press or repeat pulse that cycle. The repeat schedule is not restarted; the suppressed pulse is simply dropped.
  - sel and inc are never high in the same cycle.
  - Neither sel nor inc is emitted in the cycle the state changes.
- Idle timeout:
  - In ADJUST/TZ a 24-bit counter increments every cycle and clears on any accepted press (mode, sel or inc) and on entry to ADJUST/TZ.
  - Auto-repeat pulses also clear it.
  - When the counter reaches IDLE_TIMEOUT, the FSM goes to RUN on the next edge.
  - In RUN the counter is held at 0.
- blink:
  - In ADJUST/TZ it toggles every BLINK_HALF cycles, starting at 1 on mode entry.
  - In RUN it is forced to 0 and its counter is cleared.
- Reset mid-operation (e.g. mid-repeat or mid-debounce) returns every output to its reset value immediately. A button still held at reset release is accepted as a press once debounced.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, IDLE_TIMEOUT=100, BLINK_HALF=8):
- Mode sequencing: three clean mode presses -> adjust_mode rises 7 edges after the first, then timezone_mode, then both 0; sel=inc=0 throughout.
- Glitch rejection: btn_sel high for 3 cycles while in ADJUST -> no sel pulse, field_idx stays 0. Then six clean sel presses -> field_idx steps 1,2,3,4,5,0, one sel pulse per press.
- Auto-repeat: in ADJUST, hold btn_inc for 60 cycles -> inc pulses at the press pulse, then +20, +25, +30, ...; pulses stop within 1 cycle of the stable release. The same hold in RUN -> no inc pulses.
- Collision: sel and inc pressed simultaneously in ADJUST -> sel pulse only, and no inc pulse that cycle. mode and sel pressed together -> state advances, no sel pulse.
- Timeout: enter TZ and apply no buttons -> FSM returns to RUN 100 cycles after entry; blink toggled 1,0,1,... every 8 cycles, then is 0.
- Reset mid-repeat: assert rst during a held inc in ADJUST -> all outputs 0 asynchronously; after release with the button still held -> no pulse (state is RUN).

Source files
------------

// File: rtl/clock_ui_controller_if.sv
// Front-panel bus between the raw buttons and the clock UI controller.
// The board/button side drives the buttons; the controller drives the
// strobes and display hints back.
interface clock_ui_controller_if;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic       adjust_mode;
  logic       timezone_mode;
  logic       sel;
  logic       inc;
  logic [2:0] field_idx;
  logic       blink;

  modport master (
    output btn_mode, btn_sel, btn_inc,
    input  adjust_mode, timezone_mode, sel, inc, field_idx, blink
  );

  modport slave (
    input  btn_mode, btn_sel, btn_inc,
    output adjust_mode, timezone_mode, sel, inc, field_idx, blink
  );
endinterface

// File: rtl/clock_ui_controller.sv
// Clock UI controller: synchronises and debounces the three front-panel
// buttons, sequences RUN/ADJUST/TZ, and produces one-cycle sel/inc strobes
// (with inc auto-repeat), an inactivity timeout and a field blink hint.
module clock_ui_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000,
  parameter int unsigned IDLE_TIMEOUT    = 10000000,
  parameter int unsigned BLINK_HALF      = 250000
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_ui_controller_if.slave   bus
);

  typedef enum logic [1:0] {RUN, ADJUST, TZ} state_e;

  localparam int BTN_MODE = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_INC  = 2;

  localparam logic [23:0] DEB_LIMIT   = 24'(DEBOUNCE_CYCLES);
  localparam logic [23:0] IDLE_LIMIT  = 24'(IDLE_TIMEOUT - 1);
  localparam logic [31:0] REP_FIRST   = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] REP_NEXT    = 32'(REPEAT_RATE - 1);
  localparam logic [31:0] BLINK_LIMIT = 32'(BLINK_HALF - 1);

  logic [2:0]  rawBtn;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  stable_q, stable_d, stableDly_q;
  logic [23:0] debCnt_q [3];
  logic [23:0] debCnt_d [3];
  logic [2:0]  press;

  state_e      state_q, state_d;
  logic [23:0] idle_q, idle_d;
  logic [31:0] repCnt_q, repCnt_d;
  logic        repeating_q, repeating_d;
  logic [31:0] blinkCnt_q, blinkCnt_d;
  logic        blink_q, blink_d;
  logic        adjust_q, adjust_d;
  logic        tz_q, tz_d;
  logic        sel_q, sel_d;
  logic        inc_q, inc_d;
  logic [2:0]  field_q, field_d;

  logic        active;
  logic        held;
  logic        repFire;
  logic        activity;
  logic        timeout;
  logic        stateChange;

  assign rawBtn = {bus.btn_inc, bus.btn_sel, bus.btn_mode};

  // Debounce: count cycles the synchronised level disagrees with the accepted
  // level; accept it once the disagreement has lasted DEBOUNCE_CYCLES counts.
  // A press is the accepted level rising, seen one cycle after it is taken.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      debCnt_d[b] = '0;
      stable_d[b] = stable_q[b];
      if (sync2_q[b] != stable_q[b]) begin
        if (debCnt_q[b] == DEB_LIMIT) begin
          stable_d[b] = sync2_q[b];
        end else begin
          debCnt_d[b] = debCnt_q[b] + 24'd1;
        end
      end
    end
    press = stable_q & ~stableDly_q;
  end

  // Mode sequencing, strobe arbitration (mode > sel > inc), auto-repeat,
  // inactivity timeout and blink timing, all computed as next-state values.
  always_comb begin
    active   = (state_q != RUN);
    held     = stable_q[BTN_INC];
    repFire  = active && held &&
               (repCnt_q == (repeating_q ? REP_NEXT : REP_FIRST));
    activity = active && ((|press) || repFire);
    timeout  = active && !activity && (idle_q == IDLE_LIMIT);

    state_d = state_q;
    if (press[BTN_MODE]) begin
      case (state_q)
        RUN:     state_d = ADJUST;
        ADJUST:  state_d = TZ;
        default: state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end
    stateChange = press[BTN_MODE] || timeout;

    sel_d = active && !stateChange && press[BTN_SEL];
    inc_d = active && !stateChange && !press[BTN_SEL] &&
            (press[BTN_INC] || repFire);

    field_d = field_q;
    if (sel_d) begin
      field_d = (field_q == 3'd5) ? 3'd0 : field_q + 3'd1;
    end

    repCnt_d    = repCnt_q + 32'd1;
    repeating_d = repeating_q;
    if ((active && press[BTN_INC]) || !active || !held) begin
      repCnt_d    = '0;
      repeating_d = 1'b0;
    end else if (repFire) begin
      repCnt_d    = '0;
      repeating_d = 1'b1;
    end

    idle_d = idle_q + 24'd1;
    if (state_d == RUN || activity || press[BTN_MODE]) begin
      idle_d = '0;
    end

    blinkCnt_d = blinkCnt_q + 32'd1;
    blink_d    = blink_q;
    if (state_d == RUN) begin
      blinkCnt_d = '0;
      blink_d    = 1'b0;
    end else if (press[BTN_MODE]) begin
      blinkCnt_d = '0;
      blink_d    = 1'b1;
    end else if (blinkCnt_q == BLINK_LIMIT) begin
      blinkCnt_d = '0;
      blink_d    = ~blink_q;
    end

    adjust_d = (state_d == ADJUST);
    tz_d     = (state_d == TZ);
  end

  // All state and registered outputs; asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      stableDly_q <= '0;
      for (int b = 0; b < 3; b++) begin
        debCnt_q[b] <= '0;
      end
      state_q     <= RUN;
      idle_q      <= '0;
      repCnt_q    <= '0;
      repeating_q <= 1'b0;
      blinkCnt_q  <= '0;
      blink_q     <= 1'b0;
      adjust_q    <= 1'b0;
      tz_q        <= 1'b0;
      sel_q       <= 1'b0;
      inc_q       <= 1'b0;
      field_q     <= '0;
    end else begin
      sync1_q     <= rawBtn;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      for (int b = 0; b < 3; b++) begin
        debCnt_q[b] <= debCnt_d[b];
      end
      state_q     <= state_d;
      idle_q      <= idle_d;
      repCnt_q    <= repCnt_d;
      repeating_q <= repeating_d;
      blinkCnt_q  <= blinkCnt_d;
      blink_q     <= blink_d;
      adjust_q    <= adjust_d;
      tz_q        <= tz_d;
      sel_q       <= sel_d;
      inc_q       <= inc_d;
      field_q     <= field_d;
    end
  end

  assign bus.adjust_mode   = adjust_q;
  assign bus.timezone_mode = tz_q;
  assign bus.sel           = sel_q;
  assign bus.inc           = inc_q;
  assign bus.field_idx     = field_q;
  assign bus.blink         = blink_q;

endmodule

// File: tb/tb_clock_ui_controller.sv
// Testbench for clock_ui_controller: directed button sequences, an
// event-timed behavioural model checked every cycle, and hand-computed
// literal expectations at the interesting points.
module tb_clock_ui_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int IT = 100;
  localparam int BH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmpEn = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  int incPulses  = 0;
  int selPulses  = 0;

  clock_ui_controller_if bus ();

  clock_ui_controller #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .IDLE_TIMEOUT    (IT),
    .BLINK_HALF      (BH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Model state: per-button raw run length and accepted level, plus a short
  // history of accepted levels (a press reaches the outputs three edges
  // after the raw run completes). The mode/field/repeat/timeout/blink rules
  // are expressed as edge times rather than counters.
  int tNow;
  bit rawLvl [3];
  bit accLvl [3];
  int runLen [3];
  bit hist   [3][4];
  bit pr     [3];
  int mState, newState, mField, nextRep, lastAct, blinkStart;
  bit mActive, mHeld, mRep, mAct, mTmo, mChange;
  int expAdjust, expTz, expSel, expInc, expField, expBlink;

  // Behavioural reference, stepped on every active edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tNow = 0;
      for (int b = 0; b < 3; b++) begin
        accLvl[b] = 1'b0;
        runLen[b] = 0;
        for (int k = 0; k < 4; k++) hist[b][k] = 1'b0;
      end
      mState = 0; mField = 0; nextRep = 0; lastAct = 0; blinkStart = 0;
      expAdjust = 0; expTz = 0; expSel = 0; expInc = 0; expField = 0; expBlink = 0;
    end else begin
      tNow++;
      rawLvl[0] = bus.btn_mode;
      rawLvl[1] = bus.btn_sel;
      rawLvl[2] = bus.btn_inc;
      for (int b = 0; b < 3; b++) pr[b] = hist[b][2] && !hist[b][3];
      mHeld = hist[2][2];
      for (int b = 0; b < 3; b++) begin
        if (rawLvl[b] != accLvl[b]) begin
          runLen[b]++;
          if (runLen[b] == D + 1) begin
            accLvl[b] = rawLvl[b];
            runLen[b] = 0;
          end
        end else begin
          runLen[b] = 0;
        end
        hist[b][3] = hist[b][2];
        hist[b][2] = hist[b][1];
        hist[b][1] = hist[b][0];
        hist[b][0] = accLvl[b];
      end
      mActive  = (mState != 0);
      mRep     = mActive && mHeld && (tNow == nextRep);
      mAct     = mActive && (pr[0] || pr[1] || pr[2] || mRep);
      mTmo     = mActive && !mAct && (tNow - lastAct == IT);
      newState = pr[0] ? (mState + 1) % 3 : (mTmo ? 0 : mState);
      mChange  = pr[0] || mTmo;
      expSel   = (mActive && !mChange && pr[1]) ? 1 : 0;
      expInc   = (mActive && !mChange && !pr[1] && (pr[2] || mRep)) ? 1 : 0;
      if (expSel == 1) mField = (mField + 1) % 6;
      if (!mActive || !mHeld || pr[2]) nextRep = tNow + RD;
      else if (mRep) nextRep = tNow + RR;
      if (newState != 0 && (pr[0] || mAct)) lastAct = tNow;
      if (pr[0] && newState != 0) blinkStart = tNow;
      mState    = newState;
      expAdjust = (mState == 1) ? 1 : 0;
      expTz     = (mState == 2) ? 1 : 0;
      expField  = mField;
      expBlink  = (mState != 0 && ((tNow - blinkStart) / BH) % 2 == 0) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit m, input bit s, input bit i, input int n);
    bus.btn_mode = m;
    bus.btn_sel  = s;
    bus.btn_inc  = i;
    repeat (n) @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model_adjust_mode", int'(bus.adjust_mode), expAdjust);
      checkOutput("model_timezone_mode", int'(bus.timezone_mode), expTz);
      checkOutput("model_sel", int'(bus.sel), expSel);
      checkOutput("model_inc", int'(bus.inc), expInc);
      checkOutput("model_field_idx", int'(bus.field_idx), expField);
      checkOutput("model_blink", int'(bus.blink), expBlink);
    end
  end

  // Pulse counters for the windowed literal checks.
  always @(negedge clk) begin
    if (bus.inc === 1'b1) incPulses++;
    if (bus.sel === 1'b1) selPulses++;
  end

  int mark;

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_sel  = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_adjust_mode", int'(bus.adjust_mode), 0);
    checkOutput("reset_timezone_mode", int'(bus.timezone_mode), 0);
    checkOutput("reset_sel", int'(bus.sel), 0);
    checkOutput("reset_inc", int'(bus.inc), 0);
    checkOutput("reset_field_idx", int'(bus.field_idx), 0);
    checkOutput("reset_blink", int'(bus.blink), 0);
    rst   = 1'b1;
    cmpEn = 1'b1;
    applyStimulus(0, 0, 0, 4);

    $display("[TB] mode sequencing");
    mark = selPulses + incPulses;
    applyStimulus(1, 0, 0, 7);
    checkOutput("adjust_before_latency", int'(bus.adjust_mode), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("adjust_after_latency", int'(bus.adjust_mode), 1);
    applyStimulus(0, 0, 0, 12);
    applyStimulus(1, 0, 0, 8);
    checkOutput("tz_after_second_mode", int'(bus.timezone_mode), 1);
    checkOutput("adjust_after_second_mode", int'(bus.adjust_mode), 0);
    applyStimulus(0, 0, 0, 12);
    applyStimulus(1, 0, 0, 8);
    checkOutput("tz_after_third_mode", int'(bus.timezone_mode), 0);
    checkOutput("adjust_after_third_mode", int'(bus.adjust_mode), 0);
    applyStimulus(0, 0, 0, 12);
    checkOutput("no_strobes_during_modes", selPulses + incPulses - mark, 0);
    applyStimulus(1, 0, 0, 8);
    checkOutput("adjust_reentered", int'(bus.adjust_mode), 1);
    checkOutput("blink_on_entry", int'(bus.blink), 1);
    applyStimulus(0, 0, 0, 12);

    $display("[TB] glitch rejection and field stepping");
    mark = selPulses;
    applyStimulus(0, 1, 0, 3);
    applyStimulus(0, 0, 0, 12);
    checkOutput("glitch_sel_pulses", selPulses - mark, 0);
    checkOutput("glitch_field_idx", int'(bus.field_idx), 0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 1, 0, 7);
      applyStimulus(0, 0, 0, 1);
      checkOutput("sel_pulse_on_press", int'(bus.sel), 1);
      checkOutput("field_step", int'(bus.field_idx), k % 6);
      applyStimulus(0, 0, 0, 10);
    end
    checkOutput("six_sel_pulses", selPulses - mark, 6);

    $display("[TB] auto-repeat in ADJUST");
    mark = incPulses;
    applyStimulus(0, 0, 1, 60);
    applyStimulus(0, 0, 0, 20);
    checkOutput("repeat_pulse_count", incPulses - mark, 9);

    $display("[TB] sel+inc collision");
    mark = incPulses;
    applyStimulus(0, 1, 1, 7);
    applyStimulus(0, 0, 0, 1);
    checkOutput("collision_sel", int'(bus.sel), 1);
    checkOutput("collision_inc", int'(bus.inc), 0);
    applyStimulus(0, 0, 0, 12);
    checkOutput("collision_inc_pulses", incPulses - mark, 0);
    checkOutput("collision_field_idx", int'(bus.field_idx), 1);

    $display("[TB] mode+sel collision and timeout");
    mark = selPulses;
    applyStimulus(1, 1, 0, 7);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mode_sel_tz", int'(bus.timezone_mode), 1);
    checkOutput("mode_sel_no_sel", int'(bus.sel), 0);
    checkOutput("mode_sel_field", int'(bus.field_idx), 1);
    checkOutput("tz_blink_start", int'(bus.blink), 1);
    applyStimulus(0, 0, 0, 8);
    checkOutput("tz_blink_first_toggle", int'(bus.blink), 0);
    applyStimulus(0, 0, 0, 8);
    checkOutput("tz_blink_second_toggle", int'(bus.blink), 1);
    applyStimulus(0, 0, 0, 83);
    checkOutput("tz_before_timeout", int'(bus.timezone_mode), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("tz_after_timeout", int'(bus.timezone_mode), 0);
    checkOutput("adjust_after_timeout", int'(bus.adjust_mode), 0);
    checkOutput("blink_after_timeout", int'(bus.blink), 0);
    checkOutput("mode_sel_sel_pulses", selPulses - mark, 0);

    $display("[TB] inc hold in RUN");
    mark = incPulses;
    applyStimulus(0, 0, 1, 60);
    applyStimulus(0, 0, 0, 20);
    checkOutput("run_inc_pulses", incPulses - mark, 0);

    $display("[TB] reset during repeat");
    applyStimulus(1, 0, 0, 8);
    checkOutput("adjust_before_reset", int'(bus.adjust_mode), 1);
    applyStimulus(0, 0, 0, 12);
    bus.btn_inc = 1'b1;
    repeat (28) @(posedge clk);
    #2;
    checkOutput("repeat_pulse_at_delay", int'(bus.inc), 1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_inc", int'(bus.inc), 0);
    checkOutput("async_reset_adjust", int'(bus.adjust_mode), 0);
    checkOutput("async_reset_field", int'(bus.field_idx), 0);
    checkOutput("async_reset_blink", int'(bus.blink), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mark = incPulses;
    applyStimulus(0, 0, 1, 40);
    checkOutput("held_after_reset_inc_pulses", incPulses - mark, 0);
    checkOutput("held_after_reset_adjust", int'(bus.adjust_mode), 0);
    applyStimulus(0, 0, 0, 10);

    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
